// File: rtl/store_station_array_if.sv
// ----------------------------------------------------------------------------
// store_station_array_if
// Bundles the dispatch buses, register-file/result-bus snoop inputs and the
// store-side outputs of the store reservation-station array.
//   instbus1/2   : {source tag, ..., destination station tag}
//   reg_flat     : register values, register r at [r*DATA_W +: DATA_W]
//   cdb_flat     : result buses {tag, data}, bus k at slice k
//   data_out     : store data
//   storesig     : tag of the station whose store is on data_out
//   store_valid  : data_out/storesig valid this cycle
//   busy         : per-station occupied flag
//   full         : every station occupied
//   dispatch_err : one-cycle pulse, a dispatch was dropped
// master = dispatch side (drives buses), slave = the station array.
// ----------------------------------------------------------------------------
interface store_station_array_if #(
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 8,
  parameter int ENTRIES = 2,
  parameter int NUM_CDB = 3,
  parameter int NREG    = 4
);
  logic [TAG_W+DATA_W-1:0]         instbus1;
  logic [TAG_W+DATA_W-1:0]         instbus2;
  logic [NREG*DATA_W-1:0]          reg_flat;
  logic [NUM_CDB*(TAG_W+DATA_W)-1:0] cdb_flat;
  logic [DATA_W-1:0]               data_out;
  logic [TAG_W-1:0]                storesig;
  logic                            store_valid;
  logic [ENTRIES-1:0]              busy;
  logic                            full;
  logic                            dispatch_err;

  modport master (
    output instbus1, instbus2, reg_flat, cdb_flat,
    input  data_out, storesig, store_valid, busy, full, dispatch_err
  );

  modport slave (
    input  instbus1, instbus2, reg_flat, cdb_flat,
    output data_out, storesig, store_valid, busy, full, dispatch_err
  );
endinterface

// File: rtl/store_station_array.sv
// ----------------------------------------------------------------------------
// store_station_array
// Store reservation stations. Each station captures its store operand from
// the register file, from a same-cycle result-bus bypass, or later by
// snooping the result buses. Ready stations issue round-robin, one per cycle,
// into a LATENCY-deep store pipeline whose last stage drives the outputs.
// Ports:
//   clk : clock, all state on the rising edge
//   rst : synchronous active-high reset
//   io  : store_station_array_if.slave (dispatch buses, snoop inputs, outputs)
// ----------------------------------------------------------------------------
module store_station_array #(
  parameter int               DATA_W       = 32,
  parameter int               TAG_W        = 8,
  parameter int               ENTRIES      = 2,
  parameter int               NUM_CDB      = 3,
  parameter int               NREG         = 4,
  parameter int               LATENCY      = 2,
  parameter logic [TAG_W-1:0] BASE_TAG     = 8'h50,
  parameter logic [TAG_W-1:0] REG_TAG_BASE = 8'h10
) (
  input  logic                clk,
  input  logic                rst,
  store_station_array_if.slave io
);
  localparam int BUS_W = TAG_W + DATA_W;
  localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [BUS_W-1:0]   w_bus     [2];
  logic [TAG_W-1:0]   w_src     [2];
  logic [TAG_W-1:0]   w_dst     [2];
  logic               w_op_rdy  [2];
  logic [DATA_W-1:0]  w_op_val  [2];
  logic [TAG_W-1:0]   w_op_tag  [2];
  logic [TAG_W-1:0]   w_reg_idx;
  logic               w_found;

  logic [ENTRIES-1:0] w_valid, w_rdy, w_hit1, w_hit2, w_acc1, w_acc2, w_issue_oh;
  logic [TAG_W-1:0]   w_stn_tag [ENTRIES];
  logic [DATA_W-1:0]  w_stn_val [ENTRIES];
  logic               w_drop;
  logic               w_issue_any;
  logic [TAG_W-1:0]   w_issue_tag;
  logic [DATA_W-1:0]  w_issue_data;
  logic [PTR_W-1:0]   w_ptr_next;
  int                 w_idx;

  logic [PTR_W-1:0]   r_ptr;
  logic               r_err;
  logic               r_pv [LATENCY+1];
  logic [TAG_W-1:0]   r_pt [LATENCY+1];
  logic [DATA_W-1:0]  r_pd [LATENCY+1];

  assign w_bus[0] = io.instbus1;
  assign w_bus[1] = io.instbus2;

  // Bits between the source and destination tag fields carry nothing.
  logic w_unused;
  assign w_unused = ^{w_bus[0][BUS_W-TAG_W-1:TAG_W], w_bus[1][BUS_W-TAG_W-1:TAG_W]};

  // Operand resolution for each dispatch bus: register range first, then a
  // same-cycle result-bus bypass (lowest bus wins), otherwise wait on the tag.
  always_comb begin
    w_reg_idx = '0;
    w_found   = 1'b0;
    for (int b = 0; b < 2; b++) begin
      w_src[b]    = w_bus[b][BUS_W-1 -: TAG_W];
      w_dst[b]    = w_bus[b][TAG_W-1:0];
      w_op_rdy[b] = 1'b1;
      w_op_val[b] = '0;
      w_op_tag[b] = '0;
      w_found     = 1'b0;
      w_reg_idx   = w_src[b] - REG_TAG_BASE;
      if (w_src[b] != '0) begin
        for (int r = 0; r < NREG; r++) begin
          if (!w_found && w_reg_idx == TAG_W'(r)) begin
            w_found     = 1'b1;
            w_op_val[b] = io.reg_flat[r*DATA_W +: DATA_W];
          end
        end
        for (int k = 0; k < NUM_CDB; k++) begin
          if (!w_found && io.cdb_flat[k*BUS_W+DATA_W +: TAG_W] == w_src[b]) begin
            w_found     = 1'b1;
            w_op_val[b] = io.cdb_flat[k*BUS_W +: DATA_W];
          end
        end
        if (!w_found) begin
          w_op_rdy[b] = 1'b0;
          w_op_tag[b] = w_src[b];
        end
      end
    end
  end

  // Busy test uses the registered valid, so a station freed by this edge's
  // issue only accepts dispatches from the following cycle.
  assign w_drop = (|(w_hit1 & w_valid)) | (|(w_hit2 & (w_valid | w_hit1)));

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_stn
    logic              r_valid;
    logic              r_rdy;
    logic [DATA_W-1:0] r_value;
    logic [TAG_W-1:0]  r_wait_tag;
    logic              w_snp_hit;
    logic [DATA_W-1:0] w_snp_val;

    assign w_stn_tag[gi] = BASE_TAG + TAG_W'(gi);
    assign w_stn_val[gi] = r_value;
    assign w_valid[gi]   = r_valid;
    assign w_rdy[gi]     = r_rdy;
    assign w_hit1[gi]    = (w_dst[0] != '0) && (w_dst[0] == w_stn_tag[gi]);
    assign w_hit2[gi]    = (w_dst[1] != '0) && (w_dst[1] == w_stn_tag[gi]);
    assign w_acc1[gi]    = w_hit1[gi] & ~r_valid;
    assign w_acc2[gi]    = w_hit2[gi] & ~r_valid & ~w_hit1[gi];

    always_comb begin
      w_snp_hit = 1'b0;
      w_snp_val = '0;
      for (int k = 0; k < NUM_CDB; k++) begin
        if (!w_snp_hit && r_wait_tag != '0 &&
            io.cdb_flat[k*BUS_W+DATA_W +: TAG_W] == r_wait_tag) begin
          w_snp_hit = 1'b1;
          w_snp_val = io.cdb_flat[k*BUS_W +: DATA_W];
        end
      end
    end

    // Issue, dispatch and snoop are mutually exclusive per station:
    // issue needs valid&rdy, dispatch needs !valid, snoop needs valid&!rdy.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid    <= 1'b0;
        r_rdy      <= 1'b0;
        r_value    <= '0;
        r_wait_tag <= '0;
      end else if (w_issue_oh[gi]) begin
        r_valid    <= 1'b0;
        r_rdy      <= 1'b0;
        r_value    <= '0;
        r_wait_tag <= '0;
      end else if (w_acc1[gi]) begin
        r_valid    <= 1'b1;
        r_rdy      <= w_op_rdy[0];
        r_value    <= w_op_val[0];
        r_wait_tag <= w_op_tag[0];
      end else if (w_acc2[gi]) begin
        r_valid    <= 1'b1;
        r_rdy      <= w_op_rdy[1];
        r_value    <= w_op_val[1];
        r_wait_tag <= w_op_tag[1];
      end else if (r_valid && !r_rdy && w_snp_hit) begin
        r_rdy      <= 1'b1;
        r_value    <= w_snp_val;
        r_wait_tag <= '0;
      end
    end
  end

  // Round-robin pick: search starts at r_ptr, the station after the last
  // one issued.
  always_comb begin
    w_issue_oh   = '0;
    w_issue_any  = 1'b0;
    w_issue_tag  = '0;
    w_issue_data = '0;
    w_ptr_next   = r_ptr;
    w_idx        = 0;
    for (int k = 0; k < ENTRIES; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= ENTRIES) w_idx = w_idx - ENTRIES;
      for (int i = 0; i < ENTRIES; i++) begin
        if (i == w_idx && !w_issue_any && w_valid[i] && w_rdy[i]) begin
          w_issue_any   = 1'b1;
          w_issue_oh[i] = 1'b1;
          w_issue_tag   = w_stn_tag[i];
          w_issue_data  = w_stn_val[i];
          w_ptr_next    = (i == ENTRIES-1) ? '0 : PTR_W'(i + 1);
        end
      end
    end
  end

  // Stage 0 captures the issue; stage LATENCY is the registered output.
  // Empty slots carry zero tag/data so idle outputs read as 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_err <= 1'b0;
      for (int s = 0; s <= LATENCY; s++) begin
        r_pv[s] <= 1'b0;
        r_pt[s] <= '0;
        r_pd[s] <= '0;
      end
    end else begin
      r_err   <= w_drop;
      r_ptr   <= w_ptr_next;
      r_pv[0] <= w_issue_any;
      r_pt[0] <= w_issue_tag;
      r_pd[0] <= w_issue_data;
      for (int s = 1; s <= LATENCY; s++) begin
        r_pv[s] <= r_pv[s-1];
        r_pt[s] <= r_pt[s-1];
        r_pd[s] <= r_pd[s-1];
      end
    end
  end

  assign io.data_out     = r_pd[LATENCY];
  assign io.storesig     = r_pt[LATENCY];
  assign io.store_valid  = r_pv[LATENCY];
  assign io.busy         = w_valid;
  assign io.full         = &w_valid;
  assign io.dispatch_err = r_err;
endmodule
